// File: rtl/matrix_row_driver_if.sv
// Bundle between the column ring counter / irrigation controller and the row driver.
interface matrix_row_driver_if;
  logic [4:0] col;
  logic [1:0] image_sel;
  logic       image_req;
  logic       image_ack;
  logic [6:0] rows;
  logic       frame_start;
  logic       col_fault;

  modport master (
    output col, image_sel, image_req,
    input  image_ack, rows, frame_start, col_fault
  );

  modport slave (
    input  col, image_sel, image_req,
    output image_ack, rows, frame_start, col_fault
  );
endinterface

// File: rtl/matrix_row_driver.sv
// Row driver for a 5-column scanned status display with mirrored images.
// Rows are blanked after every column change; image swaps land only at frame start.
module matrix_row_driver #(
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  matrix_row_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE, FAULT} state_e;

  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

  state_e     state_q, state_d;
  logic [4:0] col_q;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] rows_q, rows_d;
  logic       ack_q, ack_d;
  logic       fs_q, fs_d;
  logic [1:0] active_q, active_d;
  logic       pend_q, pend_d;
  logic [1:0] pend_img_q, pend_img_d;

  logic       chg;
  logic       onehot;
  logic [1:0] idx;
  logic [6:0] rom_row;

  // Image ROM: three stored columns per image, the outer pairs are mirrored.
  function automatic logic [6:0] rom_lookup(input logic [1:0] img, input logic [1:0] col_idx);
    logic [6:0] r;
    case ({img, col_idx})
      4'b00_00: r = 7'h3E;
      4'b00_01: r = 7'h41;
      4'b00_10: r = 7'h41;
      4'b01_00: r = 7'h0C;
      4'b01_01: r = 7'h1E;
      4'b01_10: r = 7'h3F;
      4'b10_00: r = 7'h40;
      4'b10_01: r = 7'h60;
      4'b10_10: r = 7'h70;
      4'b11_00: r = 7'h41;
      4'b11_01: r = 7'h22;
      4'b11_10: r = 7'h1C;
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign onehot  = $onehot(bus.col);
  assign chg     = (bus.col != col_q);
  assign idx     = (bus.col[4] | bus.col[0]) ? 2'd0 :
                   (bus.col[3] | bus.col[1]) ? 2'd1 : 2'd2;
  assign rom_row = rom_lookup(active_q, idx);

  // Scan FSM next state: blank countdown, drive, and illegal-column handling.
  // Rows are loaded on the BLANK->DRIVE edge so the pattern appears BLANK_CYCLES+1 edges after a change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rows_d  = '0;
    case (state_q)
      IDLE: begin
        if (onehot) begin
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
        end
      end
      BLANK: begin
        if (!onehot) begin
          state_d = FAULT;
        end else if (chg) begin
          cnt_d = BLANK_LOAD;
        end else if (cnt_q == '0) begin
          state_d = DRIVE;
          rows_d  = rom_row;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DRIVE: begin
        if (!onehot) begin
          state_d = FAULT;
        end else if (chg) begin
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
        end else begin
          rows_d = rom_row;
        end
      end
      FAULT: begin
        if (onehot) begin
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame start detection and the single-entry pending image handshake.
  // Apply happens before capture so a request held at frame start is accepted in the same cycle.
  always_comb begin
    fs_d       = (state_q != FAULT) && (bus.col == 5'b10000) && (col_q != 5'b10000);
    active_d   = active_q;
    pend_d     = pend_q;
    pend_img_d = pend_img_q;
    ack_d      = 1'b0;
    if (fs_d && pend_q) begin
      active_d = pend_img_q;
      pend_d   = 1'b0;
    end
    if (bus.image_req && !ack_q && !pend_d) begin
      pend_d     = 1'b1;
      pend_img_d = bus.image_sel;
      ack_d      = 1'b1;
    end
  end

  // Scan state, sampled column and registered row drive.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      cnt_q   <= '0;
      rows_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= bus.col;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
      fs_q    <= fs_d;
    end
  end

  // Image registers: active image, pending slot and acknowledge pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q   <= '0;
      pend_q     <= 1'b0;
      pend_img_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_img_q <= pend_img_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.rows        = rows_q;
  assign bus.image_ack   = ack_q;
  assign bus.frame_start = fs_q;
  assign bus.col_fault   = (state_q == FAULT);

endmodule
